// File: rtl/register_file.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Reads are combinational; writes and reset take effect on the rising clock edge.
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  regWriteEnable,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next-state storage: reset wins over write, and entry 0 never holds anything but zero
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {DATA_WIDTH{1'b0}};
      end
    end else if (regWriteEnable && (A3 != {ADDR_WIDTH{1'b0}})) begin
      mem_d[A3] = WriteData;
    end else begin
      mem_d[0] = {DATA_WIDTH{1'b0}};
    end
    mem_d[0] = {DATA_WIDTH{1'b0}};
  end

  // Storage flops
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Zero-latency read ports; address 0 is forced so it reads zero even before the first reset
  always_comb begin
    if (A1 == {ADDR_WIDTH{1'b0}}) begin
      RD1 = {DATA_WIDTH{1'b0}};
    end else begin
      RD1 = mem_q[A1];
    end
    if (A2 == {ADDR_WIDTH{1'b0}}) begin
      RD2 = {DATA_WIDTH{1'b0}};
    end else begin
      RD2 = mem_q[A2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file plus hand sequences for
// no-bypass, combinational read, and mid-operation reset behaviour.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic [4:0] A1;
  logic [4:0] A2;
  logic [4:0] A3;
  logic [7:0] WriteData;
  logic       regWriteEnable;
  logic [7:0] RD1;
  logic [7:0] RD2;

  int n_checks;
  int n_fail;

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .A1(A1),
    .A2(A2),
    .A3(A3),
    .WriteData(WriteData),
    .regWriteEnable(regWriteEnable),
    .RD1(RD1),
    .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       we;
    logic [4:0] a3;
    logic [7:0] wd;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One clock edge with the given control, then drop controls and read back
  task automatic apply(input vec_t v, input int idx);
    rst = v.rst;
    regWriteEnable = v.we;
    A3 = v.a3;
    WriteData = v.wd;
    @(posedge clk);
    #1;
    rst = 1'b0;
    regWriteEnable = 1'b0;
    A1 = v.a1;
    A2 = v.a2;
    #1;
    check($sformatf("vec%0d_rd1", idx), RD1, v.e1);
    check($sformatf("vec%0d_rd2", idx), RD2, v.e2);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    regWriteEnable = 1'b0;
    A1 = 5'd0;
    A2 = 5'd0;
    A3 = 5'd0;
    WriteData = 8'd0;

    //            rst   we    a3     wd      a1     a2     e1      e2
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  8'h00, 5'd0,  5'd31, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 5'd0,  8'h00, 5'd5,  5'd17, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 5'd2,  8'd42, 5'd2,  5'd1,  8'd42,  8'h00};
    vecs[3]  = '{1'b0, 1'b1, 5'd4,  8'd99, 5'd4,  5'd2,  8'd99,  8'd42};
    vecs[4]  = '{1'b0, 1'b1, 5'd1,  8'd67, 5'd1,  5'd2,  8'd67,  8'd42};
    vecs[5]  = '{1'b0, 1'b0, 5'd1,  8'd5,  5'd1,  5'd1,  8'd67,  8'd67};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  8'hFF, 5'd0,  5'd4,  8'h00, 8'd99};
    vecs[7]  = '{1'b0, 1'b1, 5'd31, 8'h11, 5'd31, 5'd15, 8'h11, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 5'd15, 8'h22, 5'd15, 5'd31, 8'h22, 8'h11};
    vecs[9]  = '{1'b0, 1'b1, 5'd16, 8'h33, 5'd16, 5'd0,  8'h33, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 5'd4,  8'd7,  5'd4,  5'd2,  8'h00, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 5'd4,  8'd7,  5'd31, 5'd1,  8'h00, 8'h00};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i], i);
    end

    // No bypass: same-cycle read of the address being written shows old data
    A1 = 5'd3;
    A2 = 5'd3;
    A3 = 5'd3;
    WriteData = 8'h5A;
    regWriteEnable = 1'b1;
    #1;
    check("nobypass_before", RD1, 8'h00);
    @(posedge clk);
    #1;
    check("nobypass_after_rd1", RD1, 8'h5A);
    check("nobypass_after_rd2", RD2, 8'h5A);
    regWriteEnable = 1'b0;

    // Combinational read: address change visible without a clock edge
    A3 = 5'd8;
    WriteData = 8'hC3;
    regWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    regWriteEnable = 1'b0;
    A1 = 5'd3;
    #1;
    check("comb_read_a", RD1, 8'h5A);
    A1 = 5'd8;
    #1;
    check("comb_read_b", RD1, 8'hC3);
    A1 = 5'd24;
    #1;
    check("alias_24", RD1, 8'h00);

    // Mid-operation reset clears everything written so far
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      A1 = a[4:0];
      A2 = 5'd31 - a[4:0];
      #1;
      check($sformatf("postrst_rd1_a%0d", a), RD1, 8'h00);
      check($sformatf("postrst_rd2_a%0d", a), RD2, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
